n1_ir: RTL and testbench

Instruction register of the N1 core. It captures 16-bit opcodes fetched over the program bus, holds one stashed prefetch word, and injects forced instructions on command of the flow-control FSM. It decodes the current opcode into the `ir2fc_*` status flags and into operand fields for PAGU, PRS and ALU. It sits between the program bus read data and `N1_fc`/datapath.

---
 rtl/n1_ir_pkg.sv | 45 ++++
 rtl/n1_ir_dec.sv | 64 ++++++
 rtl/n1_ir.sv | 118 +++++++++++
 tb/tb_n1_ir.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/n1_ir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : n1_ir_pkg
// Description : Shared definitions for the N1 instruction register: opcode
//               class encoding, fixed forced opcodes and field bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package n1_ir_pkg;

    localparam logic [15:0] NOP_OPC   = 16'h0000;
    localparam logic [15:0] DROP_OPC  = 16'h0002;
    localparam logic [15:0] ZCALL_OPC = 16'hC000;

    // Field bit positions inside the 16-bit opcode
    localparam int EOW_BIT     = 0;
    localparam int MEM_RD_BIT  = 12;
    localparam int MEM_DIR_BIT = 11;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,   // 000
        CLS_MEM  = 3'd1,   // 001
        CLS_LIT  = 3'd2,   // 010
        CLS_BRA  = 3'd3,   // 011
        CLS_JUMP = 3'd4,   // 10
        CLS_CALL = 3'd5    // 11
    } opc_class_t;

    // JUMP/CALL use a 2-bit prefix, the rest a 3-bit prefix.
    function automatic opc_class_t opc_class(input logic [15:0] opc);
        opc_class_t cls;
        if (opc[15]) begin
            cls = opc[14] ? CLS_CALL : CLS_JUMP;
        end else begin
            case (opc[14:13])
                2'b00:   cls = CLS_ALU;
                2'b01:   cls = CLS_MEM;
                2'b10:   cls = CLS_LIT;
                default: cls = CLS_BRA;
            endcase
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/n1_ir_dec.sv
`default_nettype none
// ============================================================================
// Module      : n1_ir_dec
// Description : Purely combinational opcode decoder. Maps the current IR to
//               flow-control flags and operand fields.
// Ports       : opc_i            - opcode to decode
//               eow_o ... madr_sel_o - flow-control flags
//               adr_o            - jump/call/branch target (zero-extended)
//               lit_o            - literal value
//               alu_opc_o        - ALU/stack operation field
// Revision    : 1.0 - initial release
// ============================================================================
module n1_ir_dec
    import n1_ir_pkg::*;
(
    input  logic [15:0] opc_i,
    output logic        eow_o,
    output logic        eow_postpone_o,
    output logic        jump_or_call_o,
    output logic        bra_o,
    output logic        scyc_o,
    output logic        mem_o,
    output logic        mem_rd_o,
    output logic        madr_sel_o,
    output logic [13:0] adr_o,
    output logic [12:0] lit_o,
    output logic [11:0] alu_opc_o
);

    opc_class_t cls;
    logic       is_alu;
    logic       is_mem;
    logic       is_lit;

    always_comb begin
        cls    = opc_class(opc_i);
        is_alu = (cls == CLS_ALU);
        is_mem = (cls == CLS_MEM);
        is_lit = (cls == CLS_LIT);

        eow_o          = (is_alu | is_mem) & opc_i[EOW_BIT];
        // A memory access needs an extra cycle, so its end-of-word is deferred.
        eow_postpone_o = is_mem & opc_i[EOW_BIT];
        jump_or_call_o = (cls == CLS_JUMP) | (cls == CLS_CALL);
        bra_o          = (cls == CLS_BRA);
        scyc_o         = is_lit | is_alu;
        mem_o          = is_mem;
        mem_rd_o       = is_mem & opc_i[MEM_RD_BIT];
        madr_sel_o     = is_mem & opc_i[MEM_DIR_BIT];

        adr_o     = 14'h0000;
        lit_o     = 13'h0000;
        alu_opc_o = 12'h000;
        case (cls)
            CLS_JUMP, CLS_CALL: adr_o     = opc_i[13:0];
            CLS_BRA:            adr_o     = {1'b0, opc_i[12:0]};
            CLS_LIT:            lit_o     = opc_i[12:0];
            CLS_ALU:            alu_opc_o = opc_i[12:1];
            default:            ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/n1_ir.sv
`default_nettype none
// ============================================================================
// Module      : n1_ir
// Description : N1 instruction register. Captures opcodes from the program
//               bus, keeps one stashed prefetch word, injects forced opcodes
//               and decodes the current IR for FC, PAGU, PRS and ALU.
// Ports       : clk_i, sync_rst_i        - clock, sync active-high reset
//               pbus_dat_i               - program bus read data
//               fc2ir_*_i                - load/force commands from FC
//               prs2ir_ps0_i             - CALL target for force_call
//               ir2fc_*_o                - decode flags
//               ir2pagu_adr_o, ir2prs_lit_o, ir2alu_opc_o - operand fields
//               prb_ir_o, prb_ir_stash_o, prb_ir_stash_vld_o - probes
// Revision    : 1.0 - initial release
// ============================================================================
module n1_ir
    import n1_ir_pkg::*;
(
    input  logic        clk_i,
    input  logic        sync_rst_i,
    input  logic [15:0] pbus_dat_i,
    input  logic        fc2ir_capture_i,
    input  logic        fc2ir_stash_i,
    input  logic        fc2ir_expend_i,
    input  logic        fc2ir_force_eow_i,
    input  logic        fc2ir_force_0call_i,
    input  logic        fc2ir_force_call_i,
    input  logic        fc2ir_force_drop_i,
    input  logic        fc2ir_force_nop_i,
    input  logic [13:0] prs2ir_ps0_i,
    output logic        ir2fc_eow_o,
    output logic        ir2fc_eow_postpone_o,
    output logic        ir2fc_jump_or_call_o,
    output logic        ir2fc_bra_o,
    output logic        ir2fc_scyc_o,
    output logic        ir2fc_mem_o,
    output logic        ir2fc_mem_rd_o,
    output logic        ir2fc_madr_sel_o,
    output logic [13:0] ir2pagu_adr_o,
    output logic [12:0] ir2prs_lit_o,
    output logic [11:0] ir2alu_opc_o,
    output logic [15:0] prb_ir_o,
    output logic [15:0] prb_ir_stash_o,
    output logic        prb_ir_stash_vld_o
);

    logic [15:0] ir_q,    ir_d;
    logic [15:0] stash_q, stash_d;
    logic        stash_vld_q, stash_vld_d;
    logic [15:0] sel_opc;
    logic        force_load;
    logic        stash_block;

    always_comb begin
        force_load  = fc2ir_force_0call_i | fc2ir_force_call_i |
                      fc2ir_force_drop_i  | fc2ir_force_nop_i;
        stash_block = force_load | fc2ir_force_eow_i | fc2ir_capture_i;

        if (fc2ir_force_0call_i)      sel_opc = ZCALL_OPC;
        else if (fc2ir_force_call_i)  sel_opc = {2'b11, prs2ir_ps0_i};
        else if (fc2ir_force_drop_i)  sel_opc = DROP_OPC;
        else if (fc2ir_force_nop_i)   sel_opc = NOP_OPC;
        else if (fc2ir_expend_i)      sel_opc = stash_vld_q ? stash_q : NOP_OPC;
        else if (fc2ir_capture_i)     sel_opc = pbus_dat_i;
        else                          sel_opc = ir_q;

        // EOW is a field only in the ALU and MEM classes (prefix 00x).
        ir_d = sel_opc;
        if (fc2ir_force_eow_i && (sel_opc[15:14] == 2'b00)) begin
            ir_d[EOW_BIT] = 1'b1;
        end

        // The stash is consumed only when expend actually wins the IR mux;
        // a new stash in the same cycle refills it.
        stash_d     = stash_q;
        stash_vld_d = stash_vld_q;
        if (fc2ir_expend_i && !force_load) begin
            stash_vld_d = 1'b0;
        end
        if (fc2ir_stash_i && !stash_block) begin
            stash_d     = pbus_dat_i;
            stash_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            ir_q        <= NOP_OPC;
            stash_q     <= 16'h0000;
            stash_vld_q <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            stash_q     <= stash_d;
            stash_vld_q <= stash_vld_d;
        end
    end

    n1_ir_dec u_dec (
        .opc_i          (ir_q),
        .eow_o          (ir2fc_eow_o),
        .eow_postpone_o (ir2fc_eow_postpone_o),
        .jump_or_call_o (ir2fc_jump_or_call_o),
        .bra_o          (ir2fc_bra_o),
        .scyc_o         (ir2fc_scyc_o),
        .mem_o          (ir2fc_mem_o),
        .mem_rd_o       (ir2fc_mem_rd_o),
        .madr_sel_o     (ir2fc_madr_sel_o),
        .adr_o          (ir2pagu_adr_o),
        .lit_o          (ir2prs_lit_o),
        .alu_opc_o      (ir2alu_opc_o)
    );

    assign prb_ir_o           = ir_q;
    assign prb_ir_stash_o     = stash_q;
    assign prb_ir_stash_vld_o = stash_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_n1_ir.sv
`default_nettype none
// ============================================================================
// Module      : tb_n1_ir
// Description : Scoreboard testbench for n1_ir. Stimulus pushes hand-computed
//               expected state; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n1_ir;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pbus = 16'h0000;
    logic        cap = 0, stsh = 0, expd = 0, feow = 0, f0c = 0, fcall = 0, fdrop = 0, fnop = 0;
    logic [13:0] ps0 = 14'h0000;

    logic        eow, eowp, joc, bra, scyc, mem, mrd, madr;
    logic [13:0] adr;
    logic [12:0] lit;
    logic [11:0] aopc;
    logic [15:0] ir, st;
    logic        vld;

    always #5 clk = ~clk;

    n1_ir dut (
        .clk_i                (clk),
        .sync_rst_i           (rst),
        .pbus_dat_i           (pbus),
        .fc2ir_capture_i      (cap),
        .fc2ir_stash_i        (stsh),
        .fc2ir_expend_i       (expd),
        .fc2ir_force_eow_i    (feow),
        .fc2ir_force_0call_i  (f0c),
        .fc2ir_force_call_i   (fcall),
        .fc2ir_force_drop_i   (fdrop),
        .fc2ir_force_nop_i    (fnop),
        .prs2ir_ps0_i         (ps0),
        .ir2fc_eow_o          (eow),
        .ir2fc_eow_postpone_o (eowp),
        .ir2fc_jump_or_call_o (joc),
        .ir2fc_bra_o          (bra),
        .ir2fc_scyc_o         (scyc),
        .ir2fc_mem_o          (mem),
        .ir2fc_mem_rd_o       (mrd),
        .ir2fc_madr_sel_o     (madr),
        .ir2pagu_adr_o        (adr),
        .ir2prs_lit_o         (lit),
        .ir2alu_opc_o         (aopc),
        .prb_ir_o             (ir),
        .prb_ir_stash_o       (st),
        .prb_ir_stash_vld_o   (vld)
    );

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [15:0] st;
        logic        vld;
        logic [7:0]  fl;   // {eow, eow_postpone, jump_or_call, bra, scyc, mem, mem_rd, madr_sel}
        logic [13:0] adr;
        logic [12:0] lit;
        logic [11:0] opc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done = 1'b0;

    task automatic expect_state(input string nm, input logic [15:0] e_ir, input logic [15:0] e_st,
                                input logic e_v, input logic [7:0] e_fl, input logic [13:0] e_adr,
                                input logic [12:0] e_lit, input logic [11:0] e_opc);
        exp_t e;
        e.name = nm; e.ir = e_ir; e.st = e_st; e.vld = e_v; e.fl = e_fl;
        e.adr = e_adr; e.lit = e_lit; e.opc = e_opc;
        q.push_back(e);
    endtask

    // Apply the currently set controls for one rising edge, then release them.
    task automatic tick();
        @(posedge clk);
        #1;
        cap = 0; stsh = 0; expd = 0; feow = 0; f0c = 0; fcall = 0; fdrop = 0; fnop = 0;
    endtask

    // Monitor: the DUT state is always presented, so compare one queued
    // expectation on each falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] fl;
            e  = q.pop_front();
            fl = {eow, eowp, joc, bra, scyc, mem, mrd, madr};
            n_cmp++;
            if (ir !== e.ir || st !== e.st || vld !== e.vld || fl !== e.fl ||
                adr !== e.adr || lit !== e.lit || aopc !== e.opc) begin
                n_bad++;
                $display("FAIL %s: got ir=%h st=%h vld=%b fl=%b adr=%h lit=%h opc=%h, want ir=%h st=%h vld=%b fl=%b adr=%h lit=%h opc=%h",
                         e.name, ir, st, vld, fl, adr, lit, aopc,
                         e.ir, e.st, e.vld, e.fl, e.adr, e.lit, e.opc);
            end
        end
    end

    initial begin
        // Reset and idle
        tick(); tick();
        expect_state("reset", 16'h0000, 16'h0000, 1'b0, 8'b0000_1000, 14'h0, 13'h0, 12'h0);
        rst = 1'b0;
        tick();
        expect_state("idle", 16'h0000, 16'h0000, 1'b0, 8'b0000_1000, 14'h0, 13'h0, 12'h0);

        pbus = 16'h8123; cap = 1; tick();
        expect_state("cap_jump", 16'h8123, 16'h0000, 1'b0, 8'b0010_0000, 14'h0123, 13'h0, 12'h0);

        pbus = 16'h3C03; stsh = 1; tick();
        expect_state("stash_mem", 16'h8123, 16'h3C03, 1'b1, 8'b0010_0000, 14'h0123, 13'h0, 12'h0);

        expd = 1; tick();
        expect_state("expend_mem", 16'h3C03, 16'h3C03, 1'b0, 8'b1100_0111, 14'h0, 13'h0, 12'h0);

        pbus = 16'h0010; cap = 1; feow = 1; tick();
        expect_state("cap_force_eow", 16'h0011, 16'h3C03, 1'b0, 8'b1000_1000, 14'h0, 13'h0, 12'h008);

        pbus = 16'h8000; cap = 1; tick();
        expect_state("cap_8000", 16'h8000, 16'h3C03, 1'b0, 8'b0010_0000, 14'h0, 13'h0, 12'h0);

        feow = 1; tick();
        expect_state("eow_on_jump", 16'h8000, 16'h3C03, 1'b0, 8'b0010_0000, 14'h0, 13'h0, 12'h0);

        ps0 = 14'h0ABC; pbus = 16'h1111; fcall = 1; fnop = 1; cap = 1; tick();
        expect_state("call_prio", 16'hCABC, 16'h3C03, 1'b0, 8'b0010_0000, 14'h0ABC, 13'h0, 12'h0);

        expd = 1; tick();
        expect_state("expend_empty", 16'h0000, 16'h3C03, 1'b0, 8'b0000_1000, 14'h0, 13'h0, 12'h0);

        pbus = 16'h6ABC; cap = 1; tick();
        expect_state("cap_branch", 16'h6ABC, 16'h3C03, 1'b0, 8'b0001_0000, 14'h0ABC, 13'h0, 12'h0);

        pbus = 16'h5FFF; cap = 1; tick();
        expect_state("cap_literal", 16'h5FFF, 16'h3C03, 1'b0, 8'b0000_1000, 14'h0, 13'h1FFF, 12'h0);

        f0c = 1; fcall = 1; tick();
        expect_state("0call_prio", 16'hC000, 16'h3C03, 1'b0, 8'b0010_0000, 14'h0, 13'h0, 12'h0);

        fdrop = 1; fnop = 1; tick();
        expect_state("drop_prio", 16'h0002, 16'h3C03, 1'b0, 8'b0000_1000, 14'h0, 13'h0, 12'h001);

        pbus = 16'h1234; cap = 1; stsh = 1; tick();
        expect_state("stash_blocked", 16'h1234, 16'h3C03, 1'b0, 8'b0000_1000, 14'h0, 13'h0, 12'h91A);

        pbus = 16'h2001; stsh = 1; tick();
        expect_state("stash_2001", 16'h1234, 16'h2001, 1'b1, 8'b0000_1000, 14'h0, 13'h0, 12'h91A);

        pbus = 16'h4005; expd = 1; stsh = 1; tick();
        expect_state("expend_restash", 16'h2001, 16'h4005, 1'b1, 8'b1100_0100, 14'h0, 13'h0, 12'h0);

        expd = 1; tick();
        expect_state("expend_lit", 16'h4005, 16'h4005, 1'b0, 8'b0000_1000, 14'h0, 13'h0005, 12'h0);

        pbus = 16'h7777; stsh = 1; tick();
        expect_state("stash_7777", 16'h4005, 16'h7777, 1'b1, 8'b0000_1000, 14'h0, 13'h0005, 12'h0);

        rst = 1'b1; tick();
        expect_state("mid_reset", 16'h0000, 16'h0000, 1'b0, 8'b0000_1000, 14'h0, 13'h0, 12'h0);
        rst = 1'b0;

        expd = 1; tick();
        expect_state("expend_after_rst", 16'h0000, 16'h0000, 1'b0, 8'b0000_1000, 14'h0, 13'h0, 12'h0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: bench did not complete, want completion");
            $fatal(1, "timeout");
        end
    end

endmodule
`default_nettype wire
